// File: rtl/dcache_pkg.sv
// Shared types, funct3 codes and store lane helpers
// for the execute-stage data cache.
package dcache_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE    = 2'd0;
  localparam state_t RD_REQ  = 2'd1;
  localparam state_t RD_WAIT = 2'd2;
  localparam state_t WR_REQ  = 2'd3;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  function automatic logic [3:0] store_strobe(
    input logic [2:0] f3,
    input logic [1:0] off
  );
    logic [3:0] s;
    unique case (1'b1)
      (f3 == SB): s = 4'b0001 << off;
      (f3 == SH): s = 4'b0011 << {off[1], 1'b0};
      default:    s = 4'b1111;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] store_lane(
    input logic [31:0] d,
    input logic [2:0]  f3,
    input logic [1:0]  off
  );
    logic [31:0] w;
    unique case (1'b1)
      (f3 == SB): w = {24'b0, d[7:0]} << {off, 3'b000};
      (f3 == SH): w = {16'b0, d[15:0]} << {off[1], 4'b0000};
      default:    w = d;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/dcache_if.sv
// Request/response bus between the data cache
// and backing data memory.
interface dcache_if;
  logic        mem_req_valid;
  logic        mem_req_we;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;

  modport master (
    output mem_req_valid, mem_req_we, mem_req_addr,
    output mem_req_wdata, mem_req_wstrb,
    input  mem_req_ready, mem_resp_valid, mem_resp_rdata
  );

  modport slave (
    input  mem_req_valid, mem_req_we, mem_req_addr,
    input  mem_req_wdata, mem_req_wstrb,
    output mem_req_ready, mem_resp_valid, mem_resp_rdata
  );
endinterface

// File: rtl/dcache_array.sv
// Direct-mapped line storage: valid flops, tag RAM,
// byte-enabled data RAM, combinational read.
module dcache_array #(
  parameter int DATA_WIDTH = 32,
  parameter int SET_BITS   = 8,
  parameter int TAG_BITS   = 22
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [SET_BITS-1:0]     rd_idx,
  output logic                    rd_valid,
  output logic [TAG_BITS-1:0]     rd_tag,
  output logic [DATA_WIDTH-1:0]   rd_data,
  input  logic                    wr_en,
  input  logic                    fill,
  input  logic [SET_BITS-1:0]     wr_idx,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [TAG_BITS-1:0]     wr_tag
);
  localparam int SETS = 1 << SET_BITS;
  localparam int NB   = DATA_WIDTH / 8;

  logic [SETS-1:0]       valid;
  logic [TAG_BITS-1:0]   tags [SETS];
  logic [DATA_WIDTH-1:0] data [SETS];

  // valid bits: cleared by reset, set by refill
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      valid <= '0;
    else if (fill)
      valid[wr_idx] <= 1'b1;
  end

  // tag RAM written only on refill
  always_ff @(posedge clk) begin
    if (fill)
      tags[wr_idx] <= wr_tag;
  end

  // data RAM with per-byte enables
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < NB; b++) begin
        if (wr_be[b])
          data[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tags[rd_idx];
  assign rd_data  = data[rd_idx];

endmodule

// File: rtl/dcache_controller.sv
// Write-through, no-write-allocate direct-mapped
// data cache controller for the execute stage.
module dcache_controller
  import dcache_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int SET_BITS   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  LoadE,
  input  logic                  MemWriteE,
  input  logic [DATA_WIDTH-1:0] ALUResultE,
  input  logic [DATA_WIDTH-1:0] WriteDataE,
  input  logic [2:0]            AddressingControlE,
  output logic [DATA_WIDTH-1:0] cacheDataE,
  output logic                  cachehitE,
  output logic                  StallCache,
  dcache_if.master              mem
);
  localparam int TAG_BITS = DATA_WIDTH - SET_BITS - 2;

  state_t state, state_n;

  logic [DATA_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [3:0]            req_wstrb;
  logic                  req_we;

  logic [SET_BITS-1:0]   idx;
  logic [TAG_BITS-1:0]   tag;
  logic                  rd_valid;
  logic [TAG_BITS-1:0]   rd_tag;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  hit;
  logic                  is_st;
  logic                  is_ld;
  logic                  idle;
  logic [3:0]            st_be;
  logic [DATA_WIDTH-1:0] st_lane;
  logic                  fill;
  logic                  wr_en;
  logic [SET_BITS-1:0]   wr_idx;
  logic [3:0]            wr_be;
  logic [DATA_WIDTH-1:0] wr_data;

  assign idx     = ALUResultE[SET_BITS+1:2];
  assign tag     = ALUResultE[DATA_WIDTH-1:SET_BITS+2];
  assign hit     = rd_valid && (rd_tag == tag);
  assign is_st   = MemWriteE;
  assign is_ld   = LoadE && !MemWriteE;
  assign idle    = (state == IDLE);
  assign st_be   = store_strobe(AddressingControlE,
                                ALUResultE[1:0]);
  assign st_lane = store_lane(WriteDataE,
                              AddressingControlE,
                              ALUResultE[1:0]);

  assign fill    = (state == RD_WAIT) && mem.mem_resp_valid;
  assign wr_en   = fill || (idle && is_st && hit);
  assign wr_idx  = fill ? req_addr[SET_BITS+1:2] : idx;
  assign wr_be   = fill ? 4'hF : st_be;
  assign wr_data = fill ? mem.mem_resp_rdata : st_lane;

  dcache_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .SET_BITS   (SET_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_array (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_idx   (idx),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .fill     (fill),
    .wr_idx   (wr_idx),
    .wr_be    (wr_be),
    .wr_data  (wr_data),
    .wr_tag   (req_addr[DATA_WIDTH-1:SET_BITS+2])
  );

  assign cacheDataE = rd_data;
  assign cachehitE  = idle && is_ld && hit;

  // stall while a miss or store is outstanding;
  // a store releases the pipe on the accept cycle
  always_comb begin
    StallCache = 1'b0;
    unique case (state)
      IDLE:    StallCache = is_st || (is_ld && !hit);
      RD_REQ:  StallCache = 1'b1;
      RD_WAIT: StallCache = 1'b1;
      WR_REQ:  StallCache = !mem.mem_req_ready;
      default: StallCache = 1'b0;
    endcase
  end

  // next-state logic
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (is_st)
          state_n = WR_REQ;
        else if (is_ld && !hit)
          state_n = RD_REQ;
      end
      RD_REQ:
        if (mem.mem_req_ready) state_n = RD_WAIT;
      RD_WAIT:
        if (mem.mem_resp_valid) state_n = IDLE;
      WR_REQ:
        if (mem.mem_req_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_n;
  end

  // request fields captured once when leaving IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_addr  <= '0;
      req_wdata <= '0;
      req_wstrb <= '0;
      req_we    <= 1'b0;
    end else if (idle && is_st) begin
      req_addr  <= {ALUResultE[DATA_WIDTH-1:2], 2'b00};
      req_wdata <= st_lane;
      req_wstrb <= st_be;
      req_we    <= 1'b1;
    end else if (idle && is_ld && !hit) begin
      req_addr  <= {ALUResultE[DATA_WIDTH-1:2], 2'b00};
      req_wdata <= '0;
      req_wstrb <= 4'b0000;
      req_we    <= 1'b0;
    end
  end

  assign mem.mem_req_valid = (state == RD_REQ) ||
                             (state == WR_REQ);
  assign mem.mem_req_we    = req_we;
  assign mem.mem_req_addr  = req_addr;
  assign mem.mem_req_wdata = req_wdata;
  assign mem.mem_req_wstrb = req_wstrb;

endmodule
